// File: rtl/spi_pkg.sv
// Shared definitions for the FPro SPI master slot: FSM state encoding,
// register offsets within the slot and the reset value of the sclk divisor.
// Optional feature macro used by this slice: SPI_MODE_SEL_EN
// (programmable cpol/cpha; mode 0 is fixed when it is undefined).
package spi_pkg;

  // Engine states. The engine mirrors these as plain localparam codes.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPHA_DLY = 2'd1,
    ST_P0       = 2'd2,
    ST_P1       = 2'd3
  } spi_state_t;

  // Register offsets within the slot.
  localparam logic [4:0] SPI_RD_OFS   = 5'd0;
  localparam logic [4:0] SPI_SS_OFS   = 5'd1;
  localparam logic [4:0] SPI_WR_OFS   = 5'd2;
  localparam logic [4:0] SPI_CTRL_OFS = 5'd3;

  // Half-period divisor after reset: 1 MHz sclk from a 100 MHz clock.
  localparam logic [15:0] SPI_DVSR_RST = 16'd49;

endpackage

// File: rtl/spi_master_engine.sv
// Single-byte, full-duplex SPI master engine: FSM, half-period divider and
// tx/rx shift registers behind a start/ready handshake.
// Optional feature macro: SPI_MODE_SEL_EN -- when undefined the CPHA_DLY
// state is not built and transfers are always 16*(dvsr+1) clocks long.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter logic [15:0] DVSR_RST = SPI_DVSR_RST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tx_data,
  input  logic [15:0] dvsr,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        miso,
  output logic        ready,
  output logic [7:0]  rx_data,
  output logic        sclk,
  output logic        mosi
);

  localparam logic [1:0] IDLE     = ST_IDLE;
`ifdef SPI_MODE_SEL_EN
  localparam logic [1:0] CPHA_DLY = ST_CPHA_DLY;
`endif
  localparam logic [1:0] P0       = ST_P0;
  localparam logic [1:0] P1       = ST_P1;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  so_reg;
  logic [7:0]  si_reg;
  logic [15:0] dvsr_q;
  logic        cpol_q;
  logic        cpha_q;
  logic        half_done;
  logic        pclk;

  // End of the current half period: each state lasts dvsr+1 clocks.
  assign half_done = (cnt == dvsr_q);

  // FSM, divider, bit counter and shift registers.
  // NOTE: every register here is assigned with <= so all of them update
  // together from the pre-edge values; blocking = would make later
  // statements see already-updated state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      so_reg  <= '0;
      si_reg  <= '0;
      rx_data <= '0;
      dvsr_q  <= DVSR_RST;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            so_reg  <= tx_data;
            dvsr_q  <= dvsr;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            bit_cnt <= '0;
            cnt     <= '0;
`ifdef SPI_MODE_SEL_EN
            state   <= cpha ? CPHA_DLY : P0;
`else
            state   <= P0;
`endif
          end
        end
`ifdef SPI_MODE_SEL_EN
        CPHA_DLY: begin
          if (half_done) begin
            cnt   <= '0;
            state <= P0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        P0: begin
          if (half_done) begin
            si_reg <= {si_reg[6:0], miso};
            cnt    <= '0;
            state  <= P1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        P1: begin
          if (half_done) begin
            cnt <= '0;
            if (bit_cnt == 3'd7) begin
              rx_data <= si_reg;
              state   <= IDLE;
            end else begin
              so_reg  <= {so_reg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              state   <= P0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial clock: internal phase clock, inverted for cpol=1; idles at the
  // currently programmed polarity so the line settles before a start.
  // NOTE: both outputs get a value before any branch, so no path leaves
  // them unassigned and no latch is inferred.
  always_comb begin
    pclk = 1'b0;
    sclk = cpol;
    if (state != IDLE) begin
      pclk = ((state == P1) & ~cpha_q) | ((state == P0) & cpha_q);
      sclk = cpol_q ? ~pclk : pclk;
    end
  end

  assign mosi  = so_reg[7];
  assign ready = (state == IDLE);

endmodule

// File: rtl/spi_core.sv
// FPro-bus MMIO slot wrapping the SPI master engine: register file for the
// slave selects, transmit/start and control, plus the combinational read mux.
// Optional feature macro: SPI_MODE_SEL_EN -- when defined cpol/cpha are
// programmable through the control register, otherwise mode 0 is fixed.
module spi_core
  import spi_pkg::*;
#(
  parameter int          S        = 1,
  parameter logic [15:0] DVSR_RST = SPI_DVSR_RST
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  logic         wr_en;
  logic         rd_en;
  logic         start;
  logic         ready;
  logic [7:0]   rx_byte;
  logic [S-1:0] ss_n_reg;
  logic [15:0]  dvsr_reg;
  logic         cpol_reg;
  logic         cpha_reg;

  assign wr_en = cs & write;
  assign rd_en = cs & read;
  // The engine only accepts a start in IDLE, so a start while busy is dropped.
  assign start = wr_en & (addr == SPI_WR_OFS);

`ifdef SPI_MODE_SEL_EN
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[31:18];
`else
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[31:16];
  assign cpol_reg = 1'b0;
  assign cpha_reg = 1'b0;
`endif

  // Slave-select and control registers; control is latched by the engine
  // at the next start, so writes while busy do not disturb a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_n_reg <= '1;
      dvsr_reg <= DVSR_RST;
`ifdef SPI_MODE_SEL_EN
      cpol_reg <= 1'b0;
      cpha_reg <= 1'b0;
`endif
    end else if (wr_en) begin
      if (addr == SPI_SS_OFS)
        ss_n_reg <= wr_data[S-1:0];
      if (addr == SPI_CTRL_OFS) begin
        dvsr_reg <= wr_data[15:0];
`ifdef SPI_MODE_SEL_EN
        cpol_reg <= wr_data[16];
        cpha_reg <= wr_data[17];
`endif
      end
    end
  end

  spi_master_engine #(
    .DVSR_RST (DVSR_RST)
  ) u_engine (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_data (wr_data[7:0]),
    .dvsr    (dvsr_reg),
    .cpol    (cpol_reg),
    .cpha    (cpha_reg),
    .miso    (spi_miso),
    .ready   (ready),
    .rx_data (rx_byte),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi)
  );

  assign spi_ss_n = ss_n_reg;

  // Read mux: only offset 0 carries data; other offsets read back as zero.
  always_comb begin
    rd_data = '0;
    if (rd_en && (addr == SPI_RD_OFS))
      rd_data = {23'b0, ready, rx_byte};
  end

endmodule

// File: tb/tb_spi_core.sv
// Directed testbench for spi_core. Exercises mode 3 only when the
// SPI_MODE_SEL_EN macro is defined; otherwise checks that mode 0 is fixed.
module tb_spi_core;
  import spi_pkg::*;

  localparam int S = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cs = 1'b1;
  logic         read = 1'b1;
  logic         write = 1'b0;
  logic [4:0]   addr = 5'd0;
  logic [31:0]  wr_data = 32'd0;
  logic [31:0]  rd_data;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_miso;
  logic [S-1:0] spi_ss_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_core #(.S(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  // miso source: loopback of mosi, or a mode-3 slave shifting on sclk fall.
  logic       slave_en = 1'b0;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_sr = 8'd0;
  assign spi_miso = slave_en ? slave_bit : spi_mosi;

  always @(negedge spi_sclk) begin
    if (slave_en) begin
      slave_bit = slave_sr[7];
      slave_sr  = {slave_sr[6:0], 1'b0};
    end
  end

  // sclk rising-edge monitor: count edges and capture mosi as a slave would.
  int         sclk_rises = 0;
  logic [7:0] mosi_cap = 8'd0;
  always @(posedge spi_sclk) begin
    sclk_rises = sclk_rises + 1;
    mosi_cap   = {mosi_cap[6:0], spi_mosi};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    read = 1'b0; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    write = 1'b0; read = 1'b1; addr = SPI_RD_OFS;
  endtask

  // Start a transfer, optionally inject one write after inj_at low cycles,
  // and count the clocks ready stays low (bounded).
  task automatic run_xfer(input logic [7:0] tx, input int inj_at,
                          input logic [4:0] inj_addr, input logic [31:0] inj_data,
                          output int low);
    sclk_rises = 0;
    mosi_cap   = 8'd0;
    bus_write(SPI_WR_OFS, {24'd0, tx});
    low = 0;
    while (rd_data[8] !== 1'b1 && low < 5000) begin
      low = low + 1;
      if (low == inj_at) begin
        read = 1'b0; write = 1'b1; addr = inj_addr; wr_data = inj_data;
      end else begin
        write = 1'b0; read = 1'b1; addr = SPI_RD_OFS;
      end
      @(negedge clk);
    end
    write = 1'b0; read = 1'b1; addr = SPI_RD_OFS;
  endtask

  task automatic check_xfer(input string name, input int low, input int exp_low,
                            input logic [31:0] exp_rd, input logic [7:0] exp_mosi);
    vectors++;
    if (low !== exp_low) begin
      miscompares++;
      $display("FAIL %s ready_low: got %0d expected %0d", name, low, exp_low);
    end
    vectors++;
    if (rd_data !== exp_rd) begin
      miscompares++;
      $display("FAIL %s rd_data: got %h expected %h", name, rd_data, exp_rd);
    end
    vectors++;
    if (sclk_rises !== 8) begin
      miscompares++;
      $display("FAIL %s sclk_rises: got %0d expected 8", name, sclk_rises);
    end
    vectors++;
    if (mosi_cap !== exp_mosi) begin
      miscompares++;
      $display("FAIL %s mosi_bits: got %h expected %h", name, mosi_cap, exp_mosi);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_data !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL reset_rd: got %h expected %h", rd_data, 32'h0000_0100);
    end
    vectors++;
    if (spi_ss_n !== {S{1'b1}}) begin
      miscompares++;
      $display("FAIL reset_ss_n: got %b expected all ones", spi_ss_n);
    end
    vectors++;
    if (spi_sclk !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sclk: got %b expected 0", spi_sclk);
    end
    vectors++;
    if (spi_mosi !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mosi: got %b expected 0", spi_mosi);
    end
  endtask

  task automatic test_default_dvsr;
    int low;
    run_xfer(8'h5A, 0, 5'd0, 32'd0, low);
    check_xfer("default_dvsr", low, 16 * 50, 32'h0000_015A, 8'h5A);
  endtask

  task automatic test_mode0;
    int low;
    bus_write(SPI_CTRL_OFS, 32'h0000_0001);
    run_xfer(8'hA5, 0, 5'd0, 32'd0, low);
    check_xfer("mode0", low, 32, 32'h0000_01A5, 8'hA5);
    vectors++;
    if (spi_sclk !== 1'b0) begin
      miscompares++;
      $display("FAIL mode0_idle_sclk: got %b expected 0", spi_sclk);
    end
  endtask

  task automatic test_mode_sel;
    int low;
    bus_write(SPI_CTRL_OFS, 32'h0003_0001);
`ifdef SPI_MODE_SEL_EN
    vectors++;
    if (spi_sclk !== 1'b1) begin
      miscompares++;
      $display("FAIL mode3_idle_sclk: got %b expected 1", spi_sclk);
    end
    slave_sr  = 8'hC3;
    slave_bit = 1'b0;
    slave_en  = 1'b1;
    run_xfer(8'h3C, 0, 5'd0, 32'd0, low);
    check_xfer("mode3", low, 34, 32'h0000_01C3, 8'h3C);
    vectors++;
    if (spi_sclk !== 1'b1) begin
      miscompares++;
      $display("FAIL mode3_end_sclk: got %b expected 1", spi_sclk);
    end
    slave_en = 1'b0;
`else
    vectors++;
    if (spi_sclk !== 1'b0) begin
      miscompares++;
      $display("FAIL fixed_mode_idle_sclk: got %b expected 0", spi_sclk);
    end
    run_xfer(8'h3C, 0, 5'd0, 32'd0, low);
    check_xfer("fixed_mode", low, 32, 32'h0000_013C, 8'h3C);
`endif
    bus_write(SPI_CTRL_OFS, 32'h0000_0001);
  endtask

  task automatic test_back_to_back;
    int low;
    // Start while busy: ignored, original byte shifted, timing unchanged.
    run_xfer(8'hA5, 5, SPI_WR_OFS, 32'h0000_00FF, low);
    check_xfer("busy_start", low, 32, 32'h0000_01A5, 8'hA5);
    // Control write while busy: current transfer keeps dvsr=1.
    run_xfer(8'h96, 3, SPI_CTRL_OFS, 32'h0000_0000, low);
    check_xfer("busy_ctrl", low, 32, 32'h0000_0196, 8'h96);
    // Next transfer picks up dvsr=0: 1-clock half periods.
    run_xfer(8'h69, 0, 5'd0, 32'd0, low);
    check_xfer("dvsr0", low, 16, 32'h0000_0169, 8'h69);
  endtask

  task automatic test_ss;
    @(negedge clk);
    read = 1'b1; write = 1'b1; addr = SPI_SS_OFS; wr_data = 32'h0;
    #1;
    vectors++;
    if (rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL ss_read_during_write: got %h expected 0", rd_data);
    end
    @(negedge clk);
    write = 1'b0; read = 1'b1; addr = SPI_RD_OFS;
    #1;
    vectors++;
    if (spi_ss_n !== {S{1'b0}}) begin
      miscompares++;
      $display("FAIL ss_low: got %b expected 0", spi_ss_n);
    end
    addr = SPI_WR_OFS;
    #1;
    vectors++;
    if (rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_ofs2: got %h expected 0", rd_data);
    end
    addr = SPI_CTRL_OFS;
    #1;
    vectors++;
    if (rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_ofs3: got %h expected 0", rd_data);
    end
    addr = SPI_RD_OFS;
    bus_write(SPI_SS_OFS, 32'h1);
    repeat (2) @(negedge clk);
    vectors++;
    if (spi_ss_n !== {S{1'b1}}) begin
      miscompares++;
      $display("FAIL ss_high: got %b expected all ones", spi_ss_n);
    end
    vectors++;
    if (rd_data !== 32'h0000_0169) begin
      miscompares++;
      $display("FAIL ss_no_start: got %h expected %h", rd_data, 32'h0000_0169);
    end
  endtask

  task automatic test_reset_mid;
    bus_write(SPI_SS_OFS, 32'h0);
    bus_write(SPI_CTRL_OFS, 32'h0000_0001);
    bus_write(SPI_WR_OFS, 32'h0000_00A5);
    // Now in cycle 0 of the transfer; P1 of bit 3 is cycles 14..15.
    repeat (14) @(negedge clk);
    vectors++;
    if (spi_sclk !== 1'b1 || rd_data[8] !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_p1: got sclk=%b ready=%b expected sclk=1 ready=0",
               spi_sclk, rd_data[8]);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (spi_sclk !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_sclk: got %b expected 0", spi_sclk);
    end
    vectors++;
    if (rd_data !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL mid_reset_rd: got %h expected %h", rd_data, 32'h0000_0100);
    end
    vectors++;
    if (spi_ss_n !== {S{1'b1}}) begin
      miscompares++;
      $display("FAIL mid_reset_ss_n: got %b expected all ones", spi_ss_n);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (rd_data !== 32'h0000_0100 || sclk_rises !== 0 && spi_sclk !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got rd=%h sclk=%b expected rd=00000100 sclk=0",
               rd_data, spi_sclk);
    end
  endtask

  initial begin
    test_reset();
    test_default_dvsr();
    test_mode0();
    test_mode_sel();
    test_back_to_back();
    test_ss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
